// File: rtl/data_mem_bridge_if.sv
// Bus bundle between the MIPS data port, the external data memory and the wait-state bridge.
// The bridge connects through 'slave'. The core/memory side connects through 'master'.
interface data_mem_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [31:0] cpu_rdata;
  logic        cpu_hold;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;
  logic        err_clr;

  modport master (
    output cpu_addr, cpu_wdata, cpu_mem_read, cpu_mem_write, mem_ack, mem_rdata, err_clr,
    input  cpu_rdata, cpu_hold, mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_mem_read, cpu_mem_write, mem_ack, mem_rdata, err_clr,
    output cpu_rdata, cpu_hold, mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Wait-state bridge from the single-cycle core's combinational load/store strobes to a registered
// req/ack memory transaction. It stalls the core until completion and traps misalignment and timeouts.
module data_mem_bridge #(
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_bridge_if.slave  io_bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_cnt;
  logic        r_memReq;
  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic [31:0] r_cpuRdata;
  logic        r_err;

  logic w_access;
  logic w_aligned;
  logic w_bothStrobes;
  logic w_timeout;
  logic w_errEvent;
  logic w_hold;

  assign w_access      = io_bus.cpu_mem_read | io_bus.cpu_mem_write;
  assign w_aligned     = (io_bus.cpu_addr[1:0] == 2'b00);
  assign w_bothStrobes = io_bus.cpu_mem_read & io_bus.cpu_mem_write;
  // An ack in the final counted cycle still completes the access normally.
  assign w_timeout     = (r_state == REQ) && !io_bus.mem_ack && (r_cnt == TIMEOUT_CNT);
  assign w_errEvent    = ((r_state == IDLE) && w_access && (!w_aligned || w_bothStrobes)) || w_timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_nextState = w_aligned ? REQ : DONE;
        end
      end
      REQ: begin
        if (io_bus.mem_ack || w_timeout) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_hold = 1'b0;
    if (reset) begin
      w_hold = w_access && (r_state != DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_cpuRdata <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_errEvent | (r_err & ~io_bus.err_clr);
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (w_aligned) begin
              r_memReq   <= 1'b1;
              r_memWe    <= io_bus.cpu_mem_write;
              r_memAddr  <= {io_bus.cpu_addr[31:2], 2'b00};
              r_memWdata <= io_bus.cpu_wdata;
              r_cnt      <= '0;
            end else if (!io_bus.cpu_mem_write) begin
              r_cpuRdata <= ERR_RDATA;
            end
          end
        end
        REQ: begin
          if (io_bus.mem_ack) begin
            r_memReq <= 1'b0;
            if (!r_memWe) begin
              r_cpuRdata <= io_bus.mem_rdata;
            end
          end else if (r_cnt == TIMEOUT_CNT) begin
            r_memReq <= 1'b0;
            if (!r_memWe) begin
              r_cpuRdata <= ERR_RDATA;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.cpu_hold  = w_hold;
  assign io_bus.cpu_rdata = r_cpuRdata;
  assign io_bus.mem_req   = r_memReq;
  assign io_bus.mem_we    = r_memWe;
  assign io_bus.mem_addr  = r_memAddr;
  assign io_bus.mem_wdata = r_memWdata;
  assign io_bus.err       = r_err;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge with TIMEOUT=4. One stimulus vector per clock cycle.
// Every cycle's outputs are compared against hand-computed values.
module tb_data_mem_bridge;

  logic clk = 1'b0;
  logic reset;
  int   checkCount = 0;
  int   passCount  = 0;

  data_mem_bridge_if bus ();

  data_mem_bridge #(.TIMEOUT(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Drives one cycle's inputs just after the rising edge, then waits to mid-cycle for sampling.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr, input logic clr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ack, input logic [31:0] mrdata);
    @(posedge clk);
    #1;
    reset             = rst;
    bus.cpu_mem_read  = rd;
    bus.cpu_mem_write = wr;
    bus.err_clr       = clr;
    bus.cpu_addr      = addr;
    bus.cpu_wdata     = wdata;
    bus.mem_ack       = ack;
    bus.mem_rdata     = mrdata;
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic clr);
    applyStimulus(1'b1, 1'b0, 1'b0, clr, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.cpu_mem_read = 1'b0; bus.cpu_mem_write = 1'b0; bus.err_clr = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // Reset state: a pending strobe must not raise hold while reset is low.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("rst_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("rst_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("rst_we",    {31'b0, bus.mem_we},   32'd0);
    checkOutput("rst_err",   {31'b0, bus.err},      32'd0);
    checkOutput("rst_addr",  bus.mem_addr,  32'h0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_rdata", bus.cpu_rdata, 32'h0);
    idleCycle(1'b0);
    checkOutput("nonmem_hold", {31'b0, bus.cpu_hold}, 32'd0);

    // Load at 0x100, zero-wait ack.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ld_c0_hold", {31'b0, bus.cpu_hold}, 32'd1);
    checkOutput("ld_c0_req",  {31'b0, bus.mem_req},  32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1, 32'hCAFE_F00D);
    checkOutput("ld_c1_hold", {31'b0, bus.cpu_hold}, 32'd1);
    checkOutput("ld_c1_req",  {31'b0, bus.mem_req},  32'd1);
    checkOutput("ld_c1_we",   {31'b0, bus.mem_we},   32'd0);
    checkOutput("ld_c1_addr", bus.mem_addr, 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    checkOutput("ld_c2_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("ld_c2_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("ld_c2_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
    idleCycle(1'b0);

    // Store at 0x204, ack in cycle 4; read data must stay untouched.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h1234_5678, 1'b0, 32'h0);
    checkOutput("st_c0_hold", {31'b0, bus.cpu_hold}, 32'd1);
    for (int c = 1; c <= 3; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h1234_5678, 1'b0, 32'h0);
      checkOutput("st_req",   {31'b0, bus.mem_req},  32'd1);
      checkOutput("st_we",    {31'b0, bus.mem_we},   32'd1);
      checkOutput("st_addr",  bus.mem_addr,  32'h204);
      checkOutput("st_wdata", bus.mem_wdata, 32'h1234_5678);
      checkOutput("st_hold",  {31'b0, bus.cpu_hold}, 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF);
    checkOutput("st_c4_req",  {31'b0, bus.mem_req}, 32'd1);
    checkOutput("st_c4_addr", bus.mem_addr, 32'h204);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h204, 32'h1234_5678, 1'b0, 32'h0);
    checkOutput("st_c5_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("st_c5_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("st_c5_rdata", bus.cpu_rdata, 32'hCAFE_F00D);
    idleCycle(1'b0);

    // Misaligned load at 0x102, then clear.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0);
    checkOutput("mis_c0_hold", {31'b0, bus.cpu_hold}, 32'd1);
    checkOutput("mis_c0_req",  {31'b0, bus.mem_req},  32'd0);
    checkOutput("mis_c0_err",  {31'b0, bus.err},      32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 1'b0, 32'h0);
    checkOutput("mis_c1_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("mis_c1_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("mis_c1_err",   {31'b0, bus.err},      32'd1);
    checkOutput("mis_c1_rdata", bus.cpu_rdata, 32'h0);
    idleCycle(1'b1);
    checkOutput("clr_pending_err", {31'b0, bus.err}, 32'd1);
    idleCycle(1'b0);
    checkOutput("clr_done_err", {31'b0, bus.err}, 32'd0);

    // Set and clear in the same cycle: set wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0);
    checkOutput("setwins_err", {31'b0, bus.err}, 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("setwins_clr_err", {31'b0, bus.err}, 32'd0);

    // Two back-to-back loads, zero-wait each.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 1'b1, 32'h1111_1111);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 1'b0, 32'h0);
    checkOutput("b2b_a_rdata", bus.cpu_rdata, 32'h1111_1111);
    checkOutput("b2b_a_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("b2b_a_req",   {31'b0, bus.mem_req},  32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h604, 32'h0, 1'b0, 32'h0);
    checkOutput("b2b_gap_req",  {31'b0, bus.mem_req},  32'd0);
    checkOutput("b2b_b_c0_hold", {31'b0, bus.cpu_hold}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h604, 32'h0, 1'b1, 32'h2222_2222);
    checkOutput("b2b_b_req",  {31'b0, bus.mem_req}, 32'd1);
    checkOutput("b2b_b_addr", bus.mem_addr, 32'h604);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h604, 32'h0, 1'b0, 32'h0);
    checkOutput("b2b_b_rdata", bus.cpu_rdata, 32'h2222_2222);
    checkOutput("b2b_b_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    idleCycle(1'b0);

    // Timeout: load at 0x300, no ack, 5 REQ cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
      checkOutput("to_req",  {31'b0, bus.mem_req},  32'd1);
      checkOutput("to_hold", {31'b0, bus.cpu_hold}, 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    checkOutput("to_done_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("to_done_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("to_done_err",   {31'b0, bus.err},      32'd1);
    checkOutput("to_done_rdata", bus.cpu_rdata, 32'h0);
    idleCycle(1'b1);
    checkOutput("to_after_req", {31'b0, bus.mem_req}, 32'd0);
    idleCycle(1'b0);
    checkOutput("to_clr_err", {31'b0, bus.err}, 32'd0);

    // Ack arriving in the final counted REQ cycle beats the timeout.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b1, 32'h5A5A_5A5A);
    checkOutput("ackwin_req", {31'b0, bus.mem_req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0);
    checkOutput("ackwin_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("ackwin_err",   {31'b0, bus.err},      32'd0);
    checkOutput("ackwin_rdata", bus.cpu_rdata, 32'h5A5A_5A5A);
    idleCycle(1'b0);

    // Both strobes with a misaligned address: treated as a store, so read data is kept.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h701, 32'h0, 1'b0, 32'h0);
    checkOutput("both_c0_hold", {31'b0, bus.cpu_hold}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h701, 32'h0, 1'b0, 32'h0);
    checkOutput("both_c1_err",   {31'b0, bus.err},      32'd1);
    checkOutput("both_c1_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("both_c1_rdata", bus.cpu_rdata, 32'h5A5A_5A5A);
    idleCycle(1'b0);

    // Reset in cycle 2 of a pending load; a late ack afterwards is ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h9999_9999, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h9999_9999, 1'b0, 32'h0);
    checkOutput("rstreq_c1_req", {31'b0, bus.mem_req}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h500, 32'h9999_9999, 1'b0, 32'h0);
    checkOutput("rstreq_c2_hold", {31'b0, bus.cpu_hold}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h3333_3333);
    checkOutput("rstreq_req",   {31'b0, bus.mem_req},  32'd0);
    checkOutput("rstreq_hold",  {31'b0, bus.cpu_hold}, 32'd0);
    checkOutput("rstreq_err",   {31'b0, bus.err},      32'd0);
    checkOutput("rstreq_addr",  bus.mem_addr,  32'h0);
    checkOutput("rstreq_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rstreq_rdata", bus.cpu_rdata, 32'h0);
    idleCycle(1'b0);
    checkOutput("late_ack_rdata", bus.cpu_rdata, 32'h0);
    checkOutput("late_ack_req",   {31'b0, bus.mem_req}, 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
